pipelined_fwd_core: RTL and testbench

//  Parametrised 3-stage (IF/ID/EX) integer pipeline with an internal register file, decode and ALU.

---
 rtl/pipelined_fwd_core.sv | 279 +++++++++++++++++++++++++++
 tb/tb_pipelined_fwd_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_fwd_core.sv
// ---------------------------------------------------------------------------
// pipelined_fwd_core
//
// Three-stage (IF/ID -> ID/EX -> EX/writeback) integer pipeline with an
// internal register file, instruction decode and ALU. Instructions arrive on
// a valid/ready handshake; every retired instruction is reported on a
// registered writeback port and counted in retire_cnt.
//
// Read-after-write hazards between the instruction in ID and the producer in
// EX are handled in one of two ways, selected at compile time:
//   PIPE_FWD_EN defined   : the EX ALU result is forwarded into the ID operand
//                           and the pipeline never stalls.
//   PIPE_FWD_EN undefined : ID is held for one cycle (a bubble goes into EX)
//                           so the operand is read from the register file
//                           after the producer has written it.
// Architectural results are the same in both builds; only timing differs.
//
// Parameters
//   DSIZE      datapath / register width (>= 16)
//   NREGS      register count, ASIZE = $clog2(NREGS) <= 5, r0 reads as 0
//   IMM_SIGNED 0: zero-extend imm16, 1: sign-extend imm16
//   CNT_W      retire counter width (wraps)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low; wins over freeze
//   in_valid   inst_in carries an instruction
//   in_ready   pipeline accepts inst_in this cycle
//   inst_in    [31:26] op [25:21] rs [20:16] rt [15:11] rd [15:0] imm [2:0] funct
//   freeze     hold all state, suppress register file writes
//   aluout     registered EX result of the last retired instruction
//   out_valid  an instruction retired at the last (non-frozen) edge
//   out_waddr  destination of the retired instruction
//   out_wen    retired instruction wrote the register file
//   retire_cnt number of valid instructions retired
//   dbg_raddr  debug register read address
//   dbg_rdata  combinational register file read (0 for r0)
// ---------------------------------------------------------------------------
module pipelined_fwd_core #(
  parameter int DSIZE      = 32,
  parameter int NREGS      = 32,
  parameter int IMM_SIGNED = 0,
  parameter int CNT_W      = 16,
  localparam int ASIZE     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_in,
  input  logic             freeze,
  output logic [DSIZE-1:0] aluout,
  output logic             out_valid,
  output logic [ASIZE-1:0] out_waddr,
  output logic             out_wen,
  output logic [CNT_W-1:0] retire_cnt,
  input  logic [ASIZE-1:0] dbg_raddr,
  output logic [DSIZE-1:0] dbg_rdata
);

  localparam int SHW = $clog2(DSIZE);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SLT   = 3'd5,
    ALU_SLL   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

  // Register file
  logic [DSIZE-1:0] rf_q [NREGS];
  logic             rf_we;

  // IF/ID
  logic             ifid_valid_q, ifid_valid_d;
  logic [31:0]      ifid_inst_q, ifid_inst_d;

  // ID/EX
  logic             idex_valid_q, idex_valid_d;
  logic [DSIZE-1:0] idex_a_q, idex_a_d;
  logic [DSIZE-1:0] idex_b_q, idex_b_d;
  alu_op_e          idex_aluop_q, idex_aluop_d;
  logic [ASIZE-1:0] idex_dst_q, idex_dst_d;
  logic             idex_wen_q, idex_wen_d;

  // Writeback / outputs
  logic [DSIZE-1:0] aluout_q, aluout_d;
  logic             out_valid_q, out_valid_d;
  logic [ASIZE-1:0] out_waddr_q, out_waddr_d;
  logic             out_wen_q, out_wen_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  // ID stage decode
  logic [5:0]       id_op;
  logic [ASIZE-1:0] id_rs, id_rt, id_rd, id_dst;
  logic [15:0]      id_imm;
  logic [DSIZE-1:0] id_imm_ext;
  logic             id_use_imm, id_rt_used, id_wen_raw, id_wen;
  alu_op_e          id_aluop;
  logic [DSIZE-1:0] rf_rs_data, rf_rt_data;
  logic [DSIZE-1:0] id_a, id_rt_data, id_b;
  logic             haz_a, haz_b, ex_writes, stall;

  logic [DSIZE-1:0] ex_result;

  assign id_op  = ifid_inst_q[31:26];
  assign id_rs  = ifid_inst_q[21 +: ASIZE];
  assign id_rt  = ifid_inst_q[16 +: ASIZE];
  assign id_rd  = ifid_inst_q[11 +: ASIZE];
  assign id_imm = ifid_inst_q[15:0];

  // Size casts extend according to the signedness of the operand.
  assign id_imm_ext = (IMM_SIGNED != 0) ? DSIZE'($signed(id_imm)) : DSIZE'(id_imm);

  always_comb begin
    id_dst     = id_rt;
    id_use_imm = 1'b1;
    id_rt_used = 1'b0;
    id_wen_raw = 1'b0;
    id_aluop   = ALU_ADD;
    unique case (id_op)
      OP_RTYPE: begin
        id_dst     = id_rd;
        id_use_imm = 1'b0;
        id_rt_used = 1'b1;
        id_wen_raw = 1'b1;
        id_aluop   = alu_op_e'(ifid_inst_q[2:0]);
      end
      OP_ADDI: begin id_wen_raw = 1'b1; id_aluop = ALU_ADD; end
      OP_ANDI: begin id_wen_raw = 1'b1; id_aluop = ALU_AND; end
      OP_ORI:  begin id_wen_raw = 1'b1; id_aluop = ALU_OR;  end
      OP_XORI: begin id_wen_raw = 1'b1; id_aluop = ALU_XOR; end
      default: ;  // unknown op: retires as a NOP that writes nothing
    endcase
  end

  // Writes to r0 are dropped at decode so wen alone marks a real write.
  assign id_wen = id_wen_raw && (id_dst != '0);

  assign rf_rs_data = (id_rs == '0) ? '0 : rf_q[id_rs];
  assign rf_rt_data = (id_rt == '0) ? '0 : rf_q[id_rt];

  // EX wen already excludes r0, so no separate dst!=0 term is needed here.
  assign ex_writes = idex_valid_q && idex_wen_q;
  assign haz_a     = ifid_valid_q && ex_writes && (id_rs == idex_dst_q);
  assign haz_b     = ifid_valid_q && ex_writes && id_rt_used && (id_rt == idex_dst_q);

`ifdef PIPE_FWD_EN
  assign id_a       = haz_a ? ex_result : rf_rs_data;
  assign id_rt_data = haz_b ? ex_result : rf_rt_data;
  assign stall      = 1'b0;
`else
  // The producer writes the register file at the next edge, so holding ID
  // for one cycle is enough to read the new value.
  assign id_a       = rf_rs_data;
  assign id_rt_data = rf_rt_data;
  assign stall      = haz_a || haz_b;
`endif

  assign id_b = id_use_imm ? id_imm_ext : id_rt_data;

  // EX stage ALU
  always_comb begin
    ex_result = '0;
    unique case (idex_aluop_q)
      ALU_ADD:   ex_result = idex_a_q + idex_b_q;
      ALU_SUB:   ex_result = idex_a_q - idex_b_q;
      ALU_AND:   ex_result = idex_a_q & idex_b_q;
      ALU_OR:    ex_result = idex_a_q | idex_b_q;
      ALU_XOR:   ex_result = idex_a_q ^ idex_b_q;
      ALU_SLT:   ex_result = DSIZE'($signed(idex_a_q) < $signed(idex_b_q));
      ALU_SLL:   ex_result = idex_a_q << idex_b_q[SHW-1:0];
      ALU_PASSB: ex_result = idex_b_q;
      default:   ex_result = '0;
    endcase
  end

  assign in_ready = rst && !freeze && !stall;

  // Next-state: everything holds under freeze; on a stall IF/ID holds while
  // a bubble is pushed into ID/EX.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    idex_valid_d = idex_valid_q;
    idex_a_d     = idex_a_q;
    idex_b_d     = idex_b_q;
    idex_aluop_d = idex_aluop_q;
    idex_dst_d   = idex_dst_q;
    idex_wen_d   = idex_wen_q;
    aluout_d     = aluout_q;
    out_valid_d  = out_valid_q;
    out_waddr_d  = out_waddr_q;
    out_wen_d    = out_wen_q;
    retire_cnt_d = retire_cnt_q;
    if (!freeze) begin
      if (!stall) begin
        ifid_valid_d = in_valid;
        ifid_inst_d  = inst_in;
      end
      idex_valid_d = ifid_valid_q && !stall;
      idex_a_d     = id_a;
      idex_b_d     = id_b;
      idex_aluop_d = id_aluop;
      idex_dst_d   = id_dst;
      idex_wen_d   = id_wen;
      out_valid_d  = idex_valid_q;
      out_wen_d    = idex_valid_q && idex_wen_q;
      if (idex_valid_q) begin
        aluout_d     = ex_result;
        out_waddr_d  = idex_dst_q;
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= '0;
      idex_valid_q <= 1'b0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      idex_aluop_q <= ALU_ADD;
      idex_dst_q   <= '0;
      idex_wen_q   <= 1'b0;
      aluout_q     <= '0;
      out_valid_q  <= 1'b0;
      out_waddr_q  <= '0;
      out_wen_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      idex_valid_q <= idex_valid_d;
      idex_a_q     <= idex_a_d;
      idex_b_q     <= idex_b_d;
      idex_aluop_q <= idex_aluop_d;
      idex_dst_q   <= idex_dst_d;
      idex_wen_q   <= idex_wen_d;
      aluout_q     <= aluout_d;
      out_valid_q  <= out_valid_d;
      out_waddr_q  <= out_waddr_d;
      out_wen_q    <= out_wen_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Register file write happens at the same edge the instruction retires.
  assign rf_we = !freeze && idex_valid_q && idex_wen_q;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
    always_ff @(posedge clk) begin
      if (!rst) begin
        rf_q[gi] <= '0;
      end else if (rf_we && (idex_dst_q == ASIZE'(gi))) begin
        rf_q[gi] <= ex_result;
      end
    end
  end

  assign aluout     = aluout_q;
  assign out_valid  = out_valid_q;
  assign out_waddr  = out_waddr_q;
  assign out_wen    = out_wen_q;
  assign retire_cnt = retire_cnt_q;
  assign dbg_rdata  = (dbg_raddr == '0) ? '0 : rf_q[dbg_raddr];

endmodule

// File: tb/tb_pipelined_fwd_core.sv
// ---------------------------------------------------------------------------
// tb_pipelined_fwd_core
//
// Directed bench for pipelined_fwd_core (default parameters, DSIZE=32,
// IMM_SIGNED=0). A table of instructions with hand-computed results is
// streamed through the handshake; each retirement is compared in order, so
// the same table serves both the forwarding and the interlock builds
// (PIPE_FWD_EN). Hand-written sequences cover reset, the back-to-back
// dependency timing, freeze, and reset with instructions in flight.
// ---------------------------------------------------------------------------
module tb_pipelined_fwd_core;

  localparam int DSIZE = 32;
  localparam int NREGS = 32;
  localparam int ASIZE = 5;
  localparam int CNT_W = 16;

`ifdef PIPE_FWD_EN
  localparam int EXP_STALLS  = 0;
  localparam int EXP_ADD_RET = 5;
`else
  localparam int EXP_STALLS  = 1;
  localparam int EXP_ADD_RET = 6;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst_in;
  logic             freeze;
  logic [DSIZE-1:0] aluout;
  logic             out_valid;
  logic [ASIZE-1:0] out_waddr;
  logic             out_wen;
  logic [CNT_W-1:0] retire_cnt;
  logic [ASIZE-1:0] dbg_raddr;
  logic [DSIZE-1:0] dbg_rdata;

  pipelined_fwd_core #(
    .DSIZE(DSIZE), .NREGS(NREGS), .IMM_SIGNED(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(inst_in), .freeze(freeze), .aluout(aluout),
    .out_valid(out_valid), .out_waddr(out_waddr), .out_wen(out_wen),
    .retire_cnt(retire_cnt), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] exp;
    logic        wen;
    logic [4:0]  waddr;
    logic        chk_data;  // 0: result/destination not defined (NOP)
  } vec_t;

  localparam int NVEC = 23;
  vec_t vec [NVEC];

  int errors  = 0;
  int checks  = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 8'h00, 3'(fn)};
  endfunction

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] exp,
                              input logic wen, input int waddr, input logic chk_data);
    vec_t v;
    v.inst = inst; v.exp = exp; v.wen = wen; v.waddr = 5'(waddr); v.chk_data = chk_data;
    return v;
  endfunction

  // Streams vec[first +: n] through the pipeline and checks every retirement
  // in order. frz_at >= 0 raises freeze for three edges after that cycle.
  task automatic run_seq(input int first, input int n, input int frz_at,
                         output int not_ready, output int first_ret, output int last_ret);
    int issued = 0, retired = 0, cyc = 0, nfrz = 0;
    logic acc, frz_edge;
    logic [31:0] s_alu, s_cnt;
    logic        s_ov;
    not_ready = 0; first_ret = -1; last_ret = -1;
    in_valid = 1'b1;
    inst_in  = vec[first].inst;
    s_alu = '0; s_cnt = '0; s_ov = 1'b0;
    while (retired < n && cyc < 200) begin
      @(negedge clk);
      frz_edge = freeze;
      acc = in_valid && in_ready;
      if (freeze) chk("in_ready_frozen", 32'(in_ready), 32'd0);
      else if (!in_ready) not_ready++;
      @(posedge clk);
      #1;
      cyc++;
      if (frz_edge) begin
        chk("frozen_aluout", aluout, s_alu);
        chk("frozen_out_valid", 32'(out_valid), 32'(s_ov));
        chk("frozen_retire_cnt", 32'(retire_cnt), s_cnt);
      end else if (out_valid) begin
        vec_t v;
        v = vec[first + retired];
        exp_cnt++;
        $display("retire idx=%0d waddr=%0d wen=%0b data=%08h cnt=%0d",
                 first + retired, out_waddr, out_wen, aluout, retire_cnt);
        chk("out_wen", 32'(out_wen), 32'(v.wen));
        if (v.chk_data) begin
          chk("aluout", aluout, v.exp);
          chk("out_waddr", 32'(out_waddr), 32'(v.waddr));
        end
        chk("retire_cnt", 32'(retire_cnt), 32'(exp_cnt));
        if (retired == 0) first_ret = cyc;
        last_ret = cyc;
        retired++;
      end
      if (acc) begin
        issued++;
        if (issued < n) inst_in = vec[first + issued].inst;
        else in_valid = 1'b0;
      end
      if (cyc == frz_at) begin
        freeze = 1'b1;
        nfrz   = 0;
        s_alu  = aluout;
        s_ov   = out_valid;
        s_cnt  = 32'(retire_cnt);
      end else if (freeze) begin
        nfrz++;
        if (nfrz == 3) freeze = 1'b0;
      end
    end
    in_valid = 1'b0;
    freeze   = 1'b0;
    chk("retired_count", 32'(retired), 32'(n));
  endtask

  task automatic chk_reg(input string name, input int addr, input logic [31:0] exp);
    dbg_raddr = 5'(addr);
    #1;
    chk(name, dbg_rdata, exp);
  endtask

  initial begin
    int nr, fr, lr;

    vec[0]  = mk(enc_i(6'h08, 0, 1, 16'd5),      32'd5,        1, 1,  1);
    vec[1]  = mk(enc_i(6'h08, 0, 2, 16'd7),      32'd7,        1, 2,  1);
    vec[2]  = mk(enc_r(1, 2, 3, 0),              32'd12,       1, 3,  1);
    vec[3]  = mk(enc_r(3, 1, 4, 1),              32'd7,        1, 4,  1);
    vec[4]  = mk(enc_i(6'h08, 0, 5, 16'hFFFF),   32'h0000FFFF, 1, 5,  1);
    vec[5]  = mk(enc_r(5, 0, 6, 5),              32'd0,        1, 6,  1);
    vec[6]  = mk(enc_r(0, 1, 7, 1),              32'hFFFFFFFB, 1, 7,  1);
    vec[7]  = mk(enc_r(7, 1, 8, 5),              32'd1,        1, 8,  1);
    vec[8]  = mk(enc_i(6'h0C, 5, 9, 16'h0F0F),   32'h00000F0F, 1, 9,  1);
    vec[9]  = mk(enc_i(6'h0D, 9, 10, 16'hF000),  32'h0000FF0F, 1, 10, 1);
    vec[10] = mk(enc_i(6'h0E, 10, 11, 16'h00FF), 32'h0000FFF0, 1, 11, 1);
    vec[11] = mk(enc_r(1, 2, 12, 6),             32'h00000280, 1, 12, 1);
    vec[12] = mk(enc_r(1, 9, 13, 7),             32'h00000F0F, 1, 13, 1);
    vec[13] = mk(enc_r(10, 11, 14, 2),           32'h0000FF00, 1, 14, 1);
    vec[14] = mk(enc_r(3, 4, 15, 3),             32'd15,       1, 15, 1);
    vec[15] = mk(enc_r(10, 11, 16, 4),           32'h000000FF, 1, 16, 1);
    vec[16] = mk(enc_i(6'h08, 0, 0, 16'd9),      32'd9,        0, 0,  1);
    vec[17] = mk(32'hFC000000,                   32'd0,        0, 0,  0);
    vec[18] = mk(enc_i(6'h08, 7, 18, 16'd5),     32'd0,        1, 18, 1);
    vec[19] = mk(enc_i(6'h08, 0, 19, 16'd31),    32'd31,       1, 19, 1);
    vec[20] = mk(enc_r(1, 19, 20, 6),            32'h80000000, 1, 20, 1);
    vec[21] = mk(enc_r(1, 5, 21, 6),             32'h80000000, 1, 21, 1);
    vec[22] = mk(enc_r(21, 1, 22, 5),            32'd1,        1, 22, 1);

    // Reset held for two edges with a valid instruction offered.
    rst = 1'b0; freeze = 1'b0; in_valid = 1'b1; dbg_raddr = '0;
    inst_in = vec[0].inst;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_aluout", aluout, 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_retire_cnt", 32'(retire_cnt), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    for (int a = 0; a < NREGS; a++) chk_reg("reset_reg", a, 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;

    // Back-to-back dependency: ADDI r1, ADDI r2, ADD r3,r1,r2.
    run_seq(0, 3, -1, nr, fr, lr);
    chk("dep_not_ready_cycles", 32'(nr), 32'(EXP_STALLS));
    chk("dep_first_latency", 32'(fr), 32'd3);
    chk("dep_add_retire_cycle", 32'(lr), 32'(EXP_ADD_RET));

    // Remainder of the table, with a three-cycle freeze mid-stream.
    run_seq(3, NVEC - 3, 4, nr, fr, lr);
    chk("total_retire_cnt", 32'(retire_cnt), 32'(NVEC));
    chk_reg("r0_after_write", 0, 32'd0);
    chk_reg("r3", 3, 32'd12);
    chk_reg("r5_zero_ext", 5, 32'h0000FFFF);
    chk_reg("r16", 16, 32'h000000FF);
    chk_reg("r18_wrap", 18, 32'd0);
    chk_reg("r21_shift", 21, 32'h80000000);
    chk_reg("r22_slt_min", 22, 32'd1);

    // Reset with two instructions in flight.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    inst_in  = enc_i(6'h08, 0, 23, 16'd9);
    @(posedge clk);
    #1;
    inst_in  = enc_i(6'h08, 0, 24, 16'd3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("inflight_out_valid", 32'(out_valid), 32'd0);
    chk("inflight_retire_cnt", 32'(retire_cnt), 32'd0);
    chk("inflight_aluout", aluout, 32'd0);
    chk_reg("inflight_r1_cleared", 1, 32'd0);
    chk_reg("inflight_r22_cleared", 22, 32'd0);
    chk_reg("inflight_r23", 23, 32'd0);
    @(posedge clk);
    #1;
    chk("post_reset_no_retire", 32'(out_valid), 32'd0);
    chk("post_reset_cnt", 32'(retire_cnt), 32'd0);
    exp_cnt = 0;
    run_seq(0, 1, -1, nr, fr, lr);
    chk("post_reset_latency", 32'(fr), 32'd3);
    chk_reg("post_reset_r1", 1, 32'd5);
    chk_reg("post_reset_r24", 24, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
